beep_pattern_gen: RTL and testbench

//  Drive-side counterpart of the debounced key path: accepts a beep request (tone, repeat count)

---
 rtl/beep_pkg.sv | 18 +
 rtl/beep_tone_osc.sv | 27 ++
 rtl/beep_pattern_gen.sv | 114 +++++++++++
 tb/tb_beep_pattern_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and tone table for the beep pattern generator.
// Half-period constants are for a 50 MHz clock.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int HALF_W = 16;

    // Index 0..3: 523 Hz, 659 Hz, 784 Hz, 1047 Hz
    localparam logic [3:0][HALF_W-1:0] TONE_HALF = {
        16'd23877, 16'd31888, 16'd37936, 16'd47801
    };

endpackage

// File: rtl/beep_tone_osc.sv
// Square-wave oscillator: wave toggles every 'half' enabled cycles, first rise 'half' cycles after enable.
// Latency: output registered; no backpressure, wave and counter clear whenever enable is low.
module beep_tone_osc
    import beep_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half - HALF_W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/beep_pattern_gen.sv
// Plays a (tone, count) request as count ON bursts separated by OFF gaps; optional abort via BEEP_ABORT_EN.
// Latency: ON starts the cycle after accept, done pulses one cycle after the last ON; req_ready only in IDLE.
module beep_pattern_gen
    import beep_pkg::*;
#(
    parameter int                         CNT_W       = 25,
    parameter logic [CNT_W-1:0]           ON_CNT_MAX  = CNT_W'(5_000_000 - 1),
    parameter logic [CNT_W-1:0]           OFF_CNT_MAX = CNT_W'(5_000_000 - 1),
    parameter logic [3:0][HALF_W-1:0]     TONE_TAB    = TONE_HALF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_tone,
    input  logic [3:0] req_count,
`ifdef BEEP_ABORT_EN
    input  logic       abort,
`endif
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic       beep
);

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [3:0]       remaining;
    logic [1:0]       tone_q;
    logic             abort_hit;
    logic             on_last;
    logic             osc_en;

`ifdef BEEP_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign on_last   = (state == ON) && (burst_cnt == ON_CNT_MAX);
    // Drop enable on the last ON cycle so beep is already low when OFF/IDLE is entered.
    assign osc_en    = (state == ON) && !on_last && !abort_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            remaining <= '0;
            tone_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                state     <= IDLE;
                burst_cnt <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            tone_q    <= req_tone;
                            remaining <= req_count;
                            burst_cnt <= '0;
                            if (req_count == 4'd0) begin
                                done <= 1'b1;
                            end else begin
                                state <= ON;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ON: begin
                        if (burst_cnt == ON_CNT_MAX) begin
                            burst_cnt <= '0;
                            remaining <= remaining - 4'd1;
                            if (remaining == 4'd1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= OFF;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                    OFF: begin
                        if (burst_cnt == OFF_CNT_MAX) begin
                            burst_cnt <= '0;
                            state     <= ON;
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    beep_tone_osc u_osc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (osc_en),
        .half  (TONE_TAB[tone_q]),
        .wave  (beep)
    );

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed bench for beep_pattern_gen with short bursts (ON 100, OFF 50) and tone half-periods 4/5/6/7.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_beep_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_tone;
    logic [3:0] req_count;
`ifdef BEEP_ABORT_EN
    logic       abort;
`endif
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       beep;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    beep_pattern_gen #(
        .CNT_W       (25),
        .ON_CNT_MAX  (25'd99),
        .OFF_CNT_MAX (25'd49),
        .TONE_TAB    ({16'd7, 16'd6, 16'd5, 16'd4})
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tone  (req_tone),
        .req_count (req_count),
`ifdef BEEP_ABORT_EN
        .abort     (abort),
`endif
        .req_ready (req_ready),
        .busy      (busy),
        .done      (done),
        .beep      (beep)
    );

    typedef struct {
        logic [1:0] tone;
        logic [3:0] count;
        int         exp_busy;   // cycles with busy=1
        int         exp_rises;  // rising edges of beep
        int         exp_first;  // cycle (1 = first after accept) of first rise, 0 = never
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(req_ready), 1);
    endtask

    // Expected waveform rebuilt from first principles: burst b covers offsets 150*b .. 150*b+99,
    // beep is high in odd half-periods of each burst, silent in gaps.
    task automatic run_vec(input vec_t v, input int idx);
        int   h;
        int   total;
        int   busy_n = 0;
        int   rises = 0;
        int   first = 0;
        int   dones = 0;
        int   wave_err = 0;
        int   k;
        logic prev = 1'b0;
        logic eb, e_busy, e_done, e_rdy;
        h = 4 + int'(v.tone);
        wait_ready();
        req_tone  = v.tone;
        req_count = v.count;
        req_valid = 1'b1;
        total = (v.count == 0) ? 0 : int'(v.count) * 100 + (int'(v.count) - 1) * 50;
        for (int t = 1; t <= total + 2; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (t <= total) begin
                k      = (t - 1) % 150;
                eb     = (k < 100) && (((k / h) % 2) == 1);
                e_busy = 1'b1;
                e_done = 1'b0;
                e_rdy  = 1'b0;
            end else begin
                eb     = 1'b0;
                e_busy = 1'b0;
                e_done = (t == total + 1);
                e_rdy  = 1'b1;
            end
            if (beep !== eb || busy !== e_busy || done !== e_done || req_ready !== e_rdy)
                wave_err++;
            busy_n += int'(busy);
            dones  += int'(done);
            if (beep && !prev) begin
                rises++;
                if (first == 0) first = t;
            end
            prev = beep;
        end
        check($sformatf("vec%0d_waveform_errs", idx), wave_err, 0);
        check($sformatf("vec%0d_busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("vec%0d_beep_rises", idx), rises, v.exp_rises);
        check($sformatf("vec%0d_first_rise", idx), first, v.exp_first);
        check($sformatf("vec%0d_done_pulses", idx), dones, 1);
    endtask

    initial begin
        int n;
        vecs[0] = '{2'd0, 4'd1, 100, 12, 5};
        vecs[1] = '{2'd2, 4'd3, 400, 24, 7};
        vecs[2] = '{2'd1, 4'd2, 250, 20, 6};
        vecs[3] = '{2'd3, 4'd0,   0,  0, 0};
        vecs[4] = '{2'd3, 4'd1, 100,  7, 8};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_tone  = 2'd0;
        req_count = 4'd0;
`ifdef BEEP_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_beep",  int'(beep), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset in the middle of a burst while beep is high (offset 29 -> 29/4 odd).
        wait_ready();
        req_tone = 2'd0; req_count = 4'd3; req_valid = 1'b1;
        repeat (30) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("midrst_pre_busy", int'(busy), 1);
        check("midrst_pre_beep", int'(beep), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_beep",  int'(beep), 0);
        check("midrst_busy",  int'(busy), 0);
        check("midrst_ready", int'(req_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: valid held high through the first request.
        wait_ready();
        req_tone = 2'd0; req_count = 4'd1; req_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_low", int'(req_ready), 0);
        n = 1;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_cycle", n, 101);
        check("b2b_ready_with_done", int'(req_ready), 1);
        @(negedge clk);
        check("b2b_second_busy", int'(busy), 1);
        check("b2b_second_done_low", int'(done), 0);
        req_valid = 1'b0;
        n = 1;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_done_cycle", n, 101);
        @(negedge clk);

`ifdef BEEP_ABORT_EN
        // Abort in the second OFF gap (cycles 251..300 after accept).
        wait_ready();
        req_tone = 2'd2; req_count = 4'd3; req_valid = 1'b1;
        for (int t = 1; t <= 260; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  int'(busy), 0);
        check("abort_ready", int'(req_ready), 1);
        check("abort_done",  int'(done), 0);
        check("abort_beep",  int'(beep), 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(done) + int'(busy) + int'(beep);
        end
        check("abort_quiet_after", n, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
